uart_frame_tx: RTL
==================

# uart_frame_tx

Transmit-side framer for the UART DMA path. Accepts a byte stream with end-of-packet marking, such as ADC sample packets, and buffers one complete packet. It then emits that packet to the UART driver byte interface as a framed message: sync header, length, payload and checksum. It sits between the packet source and the UART byte transmitter. It produces the same frame format that the DMA receive side parses.

## Interface
- P_MAX_LEN, 255: maximum payload bytes per frame; the 8-bit length field limits it to ≤255.
- P_SYNC0, 8'h55: first header byte.
- P_SYNC1, 8'hAA: second header byte.

- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_dma_tdata  in  8  payload byte.
- i_dma_tlast  in  1  marks the last byte of a packet.
- i_dma_tvalid  in  1  tdata/tlast valid.
- o_dma_tready  out  1  framer accepts a byte this cycle.
- o_usr_tx_data  out  8  byte to the UART transmitter.
- o_usr_tx_valid  out  1  o_usr_tx_data valid.
- i_usr_tx_ready  in  1  UART transmitter accepts a byte this cycle.
- o_busy  out  1  high from the first accepted payload byte until the checksum byte is accepted.
- o_drop  out  1  one-cycle pulse for each input byte discarded by overflow.

## Operation
- Frame on the wire: P_SYNC0, P_SYNC1, LEN, payload[0..LEN-1], SUM.
  - LEN is the number of stored payload bytes (1..P_MAX_LEN).
  - SUM = (LEN + Σpayload) mod 256, computed in an 8-bit accumulator with carries discarded.
- Input beat: accepted when i_dma_tvalid && o_dma_tready. Output beat: accepted when o_usr_tx_valid && i_usr_tx_ready.
- States:
  - LOAD: o_dma_tready=1. Each accepted beat is written to the buffer at wr_cnt if wr_cnt < P_MAX_LEN; wr_cnt increments and the byte is added to SUM. If wr_cnt ≥ P_MAX_LEN, the byte is discarded and o_drop pulses. An accepted beat with tlast=1 moves to HDR0.
  - HDR0: present P_SYNC0; on accept go to HDR1.
  - HDR1: present P_SYNC1; on accept go to LEN.
  - LEN: present wr_cnt (saturated at P_MAX_LEN); on accept go to PAY with rd_cnt=0.
  - PAY: present buf[rd_cnt]; on accept increment rd_cnt. On accepting index LEN-1, go to SUM.
  - SUM: present the checksum; on accept go to LOAD, clearing wr_cnt, rd_cnt and the accumulator.
- o_dma_tready=0 in every state except LOAD. Input is back-pressured for the whole transmission; there is no overlap between frames.
- A tlast beat arriving while overflowing still terminates the packet. The frame is sent truncated with LEN=P_MAX_LEN.
- An empty packet cannot occur: tlast always accompanies a data byte.

## Timing
- Reset values:
  - o_dma_tready=0
  - o_usr_tx_valid=0
  - o_usr_tx_data=0
  - o_busy=0
  - o_drop=0
  - state LOAD, all counters 0.
- o_dma_tready rises in the first cycle after i_rst deasserts.
- Cycle N: tlast beat accepted. Cycle N+1: o_dma_tready=0 and o_usr_tx_valid=1 with P_SYNC0.
- Output stream:
  - The next byte is presented in the cycle after the previous byte is accepted.
  - With i_usr_tx_ready held at 1, valid stays high continuously: a frame of L payload bytes occupies exactly L+4 consecutive cycles.
- While o_usr_tx_valid=1 and i_usr_tx_ready=0, o_usr_tx_data and o_usr_tx_valid hold stable. Valid never drops without an acceptance.
- Cycle M: SUM accepted. Cycle M+1: o_usr_tx_valid=0, o_dma_tready=1, o_busy=0.
- Buffer reads must not add bubbles. Either prefetch buf[rd_cnt+1] or use an asynchronous read.
- o_drop is asserted in the same cycle as the discarded beat.
- Reset mid-frame, in any state:
  - The next cycle shows reset values.
  - The partial frame is abandoned and buffer contents are ignored.
  - No further bytes of that frame are emitted.

## Test plan
- Single-byte packet 0x12 with tlast, ready always 1 → 55 AA 01 12 13 on 5 consecutive cycles; o_dma_tready=0 throughout and 1 the cycle after 0x13.
- Packet 01 02 03 with ready toggling 1/0 every cycle → 55 AA 03 01 02 03 09. Each byte is held while ready=0, with no duplicates or skips.
- 300-byte packet, byte i = i mod 256, tlast on byte 299 → 45 o_drop pulses. Frame is 55 AA FF, then bytes 00..FE, then checksum 80.
- i_dma_tvalid held high with new data during transmission → o_dma_tready=0, no input accepted. The next packet starts buffering only after SUM is accepted.
- Reset asserted during the PAY state → o_usr_tx_valid=0 the next cycle. After release, a packet AB with tlast yields 55 AA 01 AB AC.
- Two packets back-to-back with tvalid continuously high → second frame begins buffering in the cycle after the first SUM is accepted. Both frames are correct.

Source files
------------

// File: rtl/uart_frame_tx.sv
// Buffers one input packet, then sends it as SYNC0 SYNC1 LEN payload SUM to the UART byte port.
// Input is back-pressured from the tlast beat until the checksum byte is taken.
module uart_frame_tx #(
  parameter int         P_MAX_LEN = 255,
  parameter logic [7:0] P_SYNC0   = 8'h55,
  parameter logic [7:0] P_SYNC1   = 8'hAA
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_dma_tdata,
  input  logic       i_dma_tlast,
  input  logic       i_dma_tvalid,
  output logic       o_dma_tready,
  output logic [7:0] o_usr_tx_data,
  output logic       o_usr_tx_valid,
  input  logic       i_usr_tx_ready,
  output logic       o_busy,
  output logic       o_drop
);

  // state | meaning
  // LOAD  | accepting payload bytes into the buffer
  // HDR0  | presenting P_SYNC0
  // HDR1  | presenting P_SYNC1
  // LEN   | presenting stored byte count
  // PAY   | presenting buffered payload bytes
  // SUM   | presenting checksum
  typedef enum logic [2:0] {S_LOAD, S_HDR0, S_HDR1, S_LEN, S_PAY, S_SUM} state_t;

  localparam logic [7:0] MAX_LEN = 8'(P_MAX_LEN);

  state_t     state;
  logic [7:0] mem [P_MAX_LEN];
  logic [7:0] wr_cnt;
  logic [7:0] rd_cnt;
  logic [7:0] sum_acc;
  logic       in_beat;
  logic       out_beat;
  logic       store;

  assign in_beat  = i_dma_tvalid && o_dma_tready && (state == S_LOAD);
  assign out_beat = o_usr_tx_valid && i_usr_tx_ready;
  assign store    = in_beat && (wr_cnt < MAX_LEN);
  // Drop is combinational so it lines up with the discarded beat itself.
  assign o_drop   = in_beat && !(wr_cnt < MAX_LEN);

  always_ff @(posedge i_clk) begin
    if (store) mem[wr_cnt] <= i_dma_tdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= S_LOAD;
      wr_cnt         <= 8'd0;
      rd_cnt         <= 8'd0;
      sum_acc        <= 8'd0;
      o_dma_tready   <= 1'b0;
      o_usr_tx_valid <= 1'b0;
      o_usr_tx_data  <= 8'd0;
      o_busy         <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          o_dma_tready <= 1'b1;
          if (in_beat) begin
            o_busy <= 1'b1;
            if (store) begin
              wr_cnt  <= wr_cnt + 8'd1;
              sum_acc <= sum_acc + i_dma_tdata;
            end
            if (i_dma_tlast) begin
              state          <= S_HDR0;
              o_dma_tready   <= 1'b0;
              o_usr_tx_valid <= 1'b1;
              o_usr_tx_data  <= P_SYNC0;
            end
          end
        end
        S_HDR0: if (out_beat) begin
          state         <= S_HDR1;
          o_usr_tx_data <= P_SYNC1;
        end
        S_HDR1: if (out_beat) begin
          state         <= S_LEN;
          o_usr_tx_data <= wr_cnt;
        end
        S_LEN: if (out_beat) begin
          state         <= S_PAY;
          rd_cnt        <= 8'd0;
          o_usr_tx_data <= mem[8'd0];
        end
        S_PAY: if (out_beat) begin
          // Next byte is read ahead so the stream has no bubbles.
          if (rd_cnt == wr_cnt - 8'd1) begin
            state         <= S_SUM;
            o_usr_tx_data <= sum_acc + wr_cnt;
          end else begin
            rd_cnt        <= rd_cnt + 8'd1;
            o_usr_tx_data <= mem[rd_cnt + 8'd1];
          end
        end
        S_SUM: if (out_beat) begin
          state          <= S_LOAD;
          o_usr_tx_valid <= 1'b0;
          o_usr_tx_data  <= 8'd0;
          o_dma_tready   <= 1'b1;
          o_busy         <= 1'b0;
          wr_cnt         <= 8'd0;
          rd_cnt         <= 8'd0;
          sum_acc        <= 8'd0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
